// File: rtl/cdm_seq_mul_if.sv
// ---------------------------------------------------------------------------
// cdm_seq_mul_if
//   Streaming handshake bundle for the iterative carry-disregard multiplier.
//   The producer side offers operands with in_valid/in_ready; the consumer side
//   takes products with out_valid/out_ready.
//
//   Signals
//     in_valid   producer -> block   operand transaction offered
//     in_ready   block -> producer   block can accept a transaction
//     A, B       producer -> block   W-bit unsigned operands
//     MODE       producer -> block   0 = exact, 1 = approximate accumulation
//     out_valid  block -> consumer   R holds a finished product
//     out_ready  consumer -> block   consumer takes R
//     R          block -> consumer   2W-bit product
//     R_mode     block -> consumer   MODE value that produced R
//
//   Modports
//     master  the environment (drives operands and out_ready)
//     slave   the multiplier itself
// ---------------------------------------------------------------------------
interface cdm_seq_mul_if #(
  parameter int W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             MODE;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   R;
  logic             R_mode;

  modport master (
    output in_valid,
    output A,
    output B,
    output MODE,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  R,
    input  R_mode
  );

  modport slave (
    input  in_valid,
    input  A,
    input  B,
    input  MODE,
    input  out_ready,
    output in_ready,
    output out_valid,
    output R,
    output R_mode
  );

endinterface : cdm_seq_mul_if

// File: rtl/cdm_seq_mul.sv
// ---------------------------------------------------------------------------
// cdm_seq_mul
//   Iterative unsigned W x W multiplier. B is consumed one 4-bit digit per
//   cycle, least significant digit first. Each partial row (A * digit, shifted
//   into place) is accumulated with a carry-disregard adder: in approximate
//   mode the lowest APPROX_BITS columns are combined with a bitwise OR and
//   never generate a carry; the remaining columns add normally with the final
//   carry-out dropped. In exact mode the adder degenerates to a plain 2W-bit
//   sum, so the product is exact.
//
//   One transaction is in flight at a time: IDLE -> RUN (W/4 cycles) -> DONE.
//   The result is held in DONE until the consumer takes it.
//
//   Parameters
//     W            operand width, multiple of 4, >= 8 (product is 2W bits)
//     APPROX_BITS  carry-disregard columns used when MODE = 1, 0 .. 2W-1
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous reset, active-high
//     bus   cdm_seq_mul_if slave modport (handshakes, operands, result)
// ---------------------------------------------------------------------------
module cdm_seq_mul #(
  parameter int W           = 8,
  parameter int APPROX_BITS = 6
) (
  input  logic          clk,
  input  logic          rst,
  cdm_seq_mul_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int PW = 2 * W;                         // product width
  localparam int ND = W / 4;                         // number of B digits
  localparam int SW = (ND > 1) ? $clog2(ND) : 1;     // digit counter width

  localparam logic [SW-1:0] LAST_STEP = SW'(ND - 1);

  // Columns [APPROX_BITS-1:0] set: these are OR-combined in approximate mode.
  localparam logic [PW-1:0] APPROX_MASK = (PW'(1) << APPROX_BITS) - PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e          state_q, state_d;

  logic [W-1:0]    a_q,      a_d;
  logic [W-1:0]    b_q,      b_d;
  logic            mode_q,   mode_d;
  logic [PW-1:0]   acc_q,    acc_d;
  logic [SW-1:0]   step_q,   step_d;
  logic [PW-1:0]   r_q,      r_d;
  logic            r_mode_q, r_mode_d;

  // -------------------------------------------------------------------------
  // Datapath helpers
  // -------------------------------------------------------------------------
  logic            accept;
  logic            last_step;
  logic [3:0]      digit;
  logic [W+3:0]    prod;
  logic [PW-1:0]   row;
  logic [PW-1:0]   cd_mask;
  logic [PW-1:0]   hi_sum;
  logic [PW-1:0]   acc_next;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign last_step = (step_q == LAST_STEP);

  always_comb begin
    // NOTE: every signal written here gets a value on every path (defaults
    // first); a path that leaves one unassigned would infer a latch.
    digit    = b_q[4*step_q +: 4];
    prod     = (W+4)'(a_q) * (W+4)'(digit);
    row      = PW'(prod) << (4 * step_q);

    // Carry-disregard add. With the low columns masked off in both operands,
    // the upper sum receives no carry from below; the low columns are simply
    // OR-ed. A zero mask (exact mode) makes this an ordinary modulo-2^PW add.
    cd_mask  = mode_q ? APPROX_MASK : '0;
    hi_sum   = (acc_q & ~cd_mask) + (row & ~cd_mask);
    acc_next = hi_sum | ((acc_q | row) & cd_mask);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values, independent of statement order.
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_step)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (all derived from registered state)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.R         = r_q;
    bus.R_mode    = r_mode_q;
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    step_d   = step_q;
    r_d      = r_q;
    r_mode_d = r_mode_q;

    if (accept) begin
      // Operands are captured once; later changes on A/B/MODE are ignored.
      a_d    = bus.A;
      b_d    = bus.B;
      mode_d = bus.MODE;
      acc_d  = '0;
      step_d = '0;
    end else if (state_q == RUN) begin
      // Every digit takes a cycle, zero or not: latency is fixed at ND.
      acc_d  = acc_next;
      step_d = step_q + SW'(1);
      if (last_step) begin
        r_d      = acc_next;
        r_mode_d = mode_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      step_q   <= '0;
      r_q      <= '0;
      r_mode_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      r_q      <= r_d;
      r_mode_q <= r_mode_d;
    end
  end

endmodule : cdm_seq_mul

// File: tb/tb_cdm_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_cdm_seq_mul
//   Self-checking bench for cdm_seq_mul. Two instances share clk/rst:
//     dut8   W=8,  APPROX_BITS=6  directed corner cases, reset, hold, random
//     dut16  W=16, APPROX_BITS=6  back-to-back random stream (exact, approx)
//   Expected products come from an arithmetic model of the carry-disregard
//   accumulation, computed digit by digit with plain integer operations.
// ---------------------------------------------------------------------------
module tb_cdm_seq_mul;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cdm_seq_mul_if #(.W(8))  bus8 ();
  cdm_seq_mul_if #(.W(16)) bus16 ();

  cdm_seq_mul #(.W(8),  .APPROX_BITS(6)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  cdm_seq_mul #(.W(16), .APPROX_BITS(6)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int n_checks = 0;
  int n_fail   = 0;
  longint cyc  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sum of shifted digit rows with the low k columns OR-ed and
  // the upper columns added modulo 2^(2w-k).
  function automatic longint model(input int w, input int ab, input longint a,
                                   input longint b, input bit m);
    longint pmod, lmod, acc, d, row;
    int k;
    pmod = longint'(1) << (2 * w);
    k    = m ? ab : 0;
    lmod = longint'(1) << k;
    acc  = 0;
    for (int i = 0; i < w / 4; i++) begin
      d   = (b >> (4 * i)) % 16;
      row = ((a * d) << (4 * i)) % pmod;
      acc = ((((acc / lmod) + (row / lmod)) % (pmod / lmod)) * lmod)
            + ((acc % lmod) | (row % lmod));
    end
    return acc;
  endfunction

  // Offer one 8-bit transaction, scramble the inputs after accept and wait
  // (bounded) for out_valid. n = edges after the accept edge.
  task automatic accept_wait8(input logic [7:0] a, input logic [7:0] b,
                              input logic m, output int n);
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.A        = a;
    bus8.B        = b;
    bus8.MODE     = m;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.A        = ~a;
    bus8.B        = 8'($urandom);
    bus8.MODE     = ~m;
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m,
                      input string tag);
    longint exp;
    int n;
    exp = model(8, 6, a, b, m);
    @(negedge clk);
    check({tag, "_in_ready"}, bus8.in_ready, 1);
    accept_wait8(a, b, m, n);
    check({tag, "_latency"}, n, 2);
    check({tag, "_R"}, bus8.R, exp);
    check({tag, "_R_mode"}, bus8.R_mode, m);
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check({tag, "_ov_clear"}, bus8.out_valid, 0);
  endtask

  // -------------------------------------------------------------------------
  // 16-bit back-to-back stream
  // -------------------------------------------------------------------------
  longint exp_q[$];
  longint exact_q[$];
  bit     mode_q[$];

  localparam int N16 = 2000;

  task automatic drive16();
    longint first_acc, last_acc;
    int w;
    logic [15:0] a, b;
    logic m;
    first_acc = 0;
    last_acc  = 0;
    for (int i = 0; i < N16; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i == 0 || i == N16 / 2) begin a = 16'hFFFF; b = 16'hFFFF; end
      if (i == 1) begin a = 16'h0000; b = 16'h1234; end
      if (i == 2) begin a = 16'h8001; b = 16'h0000; end
      m = (i >= N16 / 2);
      bus16.in_valid = 1'b1;
      bus16.A        = a;
      bus16.B        = b;
      bus16.MODE     = m;
      w = 0;
      while (!bus16.in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        check("w16_accept_timeout", w, 0);
        break;
      end
      exp_q.push_back(model(16, 6, a, b, m));
      exact_q.push_back(longint'(a) * longint'(b));
      mode_q.push_back(m);
      if (i == 0) first_acc = cyc;
      last_acc = cyc;
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    check("w16_throughput", last_acc - first_acc, longint'(N16 - 1) * 6);
  endtask

  task automatic monitor16();
    int got, idle;
    longint e, ex;
    bit m;
    got  = 0;
    idle = 0;
    while (got < N16 && idle < 100) begin
      @(negedge clk);
      if (bus16.out_valid) begin
        idle = 0;
        if (exp_q.size() == 0) begin
          check("w16_spurious_out", bus16.R, 0);
          got++;
        end else begin
          e  = exp_q.pop_front();
          ex = exact_q.pop_front();
          m  = mode_q.pop_front();
          check(m ? "w16_R_approx" : "w16_R_exact", bus16.R, e);
          check("w16_R_mode", bus16.R_mode, m);
          if (m) check("w16_R_le_exact", longint'(bus16.R) <= ex, 1);
          got++;
        end
      end else begin
        idle++;
      end
    end
    if (got < N16) check("w16_result_timeout", got, N16);
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int n;

    rst             = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.A          = '0;
    bus8.B          = '0;
    bus8.MODE       = 1'b0;
    bus8.out_ready  = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.A         = '0;
    bus16.B         = '0;
    bus16.MODE      = 1'b0;
    bus16.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_in_ready",  bus8.in_ready, 1);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_R",         bus8.R, 0);
    check("rst_R_mode",    bus8.R_mode, 0);
    check("rst16_in_ready", bus16.in_ready, 1);
    rst = 1'b0;

    // Directed corner cases (W=8)
    run8(8'hFF, 8'hFF, 1'b0, "ff_exact");
    check("ff_exact_value", bus8.R, 16'hFE01);
    run8(8'hFF, 8'hFF, 1'b1, "ff_approx");
    check("ff_approx_value", bus8.R, 16'hFDF1);
    run8(8'h0F, 8'h22, 1'b1, "disjoint_approx");
    check("disjoint_value", bus8.R, 16'h01FE);
    run8(8'h00, 8'hA5, 1'b0, "a_zero");
    run8(8'hC3, 8'h00, 1'b1, "b_zero");

    // Hold result in DONE while the consumer stalls; new offers are ignored.
    accept_wait8(8'h12, 8'h34, 1'b0, n);
    check("hold_R_initial", bus8.R, 16'h03A8);
    bus8.in_valid = 1'b1;
    bus8.A        = 8'h55;
    bus8.B        = 8'h66;
    bus8.MODE     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", bus8.out_valid, 1);
      check("hold_R",         bus8.R, 16'h03A8);
      check("hold_R_mode",    bus8.R_mode, 0);
      check("hold_in_ready",  bus8.in_ready, 0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("hold_release_ov", bus8.out_valid, 0);
    check("hold_release_rdy", bus8.in_ready, 1);

    // Reset one cycle after accept: in-flight work is discarded.
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.A        = 8'hAB;
    bus8.B        = 8'hCD;
    bus8.MODE     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("pre_rst_in_ready", bus8.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus8.out_valid, 0);
    check("mid_rst_R",         bus8.R, 0);
    check("mid_rst_in_ready",  bus8.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_no_output", bus8.out_valid, 0);
    run8(8'd3, 8'd5, 1'b0, "post_rst");
    check("post_rst_value", bus8.R, 16'd15);

    // Random W=8 transactions, both modes
    for (int i = 0; i < 40; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
    end

    // W=16 back-to-back stream
    fork
      drive16();
      monitor16();
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cdm_seq_mul
